// File: rtl/act_pkg.sv
// Shared types and Q8.8 constants for the bias/activation stage.
package act_pkg;

  typedef enum logic [1:0] {
    READY = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ACT_PASS  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_HSIG  = 2'd2,
    ACT_HTANH = 2'd3
  } act_mode_e;

  localparam logic signed [15:0] Q_ONE     = 16'sd256;
  localparam logic signed [15:0] Q_HALF    = 16'sd128;
  localparam logic signed [15:0] Q_NEG_ONE = -16'sd256;

endpackage

// File: rtl/hard_act.sv
// Combinational hard activation on a signed Q8.8 value.
module hard_act
  import act_pkg::*;
(
  input  act_mode_e          mode,
  input  logic signed [15:0] x,
  output logic signed [15:0] y
);

  logic signed [15:0] hsig;

  // Select the activation; the shift cannot overflow, so hsig fits in 16 bits.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    y    = x;
    hsig = (x >>> 2) + Q_HALF;
    case (mode)
      ACT_PASS:  y = x;
      ACT_RELU:  y = x[15] ? 16'sd0 : x;
      ACT_HSIG: begin
        if (hsig < 16'sd0)      y = 16'sd0;
        else if (hsig > Q_ONE)  y = Q_ONE;
        else                    y = hsig;
      end
      ACT_HTANH: begin
        if (x < Q_NEG_ONE)      y = Q_NEG_ONE;
        else if (x > Q_ONE)     y = Q_ONE;
        else                    y = x;
      end
      default:   y = x;
    endcase
  end

endmodule

// File: rtl/bias_act.sv
// Reads a Q8.8 vector plus bias, adds with saturation, applies a hard
// activation and writes the result through a 2-stage pipeline.
module bias_act
  import act_pkg::*;
#(
  parameter int LEN      = 4,
  parameter int IDX_BITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [15:0]         src_data,
  input  logic [15:0]         bias_data,
  output logic [IDX_BITS-1:0] src_sel,
  output logic [IDX_BITS-1:0] dst_sel,
  output logic [15:0]         dst_data,
  output logic                dst_write,
  output logic                ready,
  output logic                busy,
  output logic                done
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(LEN - 1);

  state_e              state, state_nxt;
  act_mode_e           mode_q;
  logic [IDX_BITS-1:0] cnt;
  logic                drain_cnt;

  logic signed [16:0]  sum;
  logic signed [15:0]  sat;
  logic signed [15:0]  s1_sat;
  logic                s1_valid;
  logic [IDX_BITS-1:0] s1_idx;
  logic signed [15:0]  act_y;

  // State register plus issue/drain counters and the mode latched at start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= READY;
      mode_q    <= ACT_PASS;
      cnt       <= '0;
      drain_cnt <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state <= state_nxt;
      case (state)
        READY: if (start) begin
          mode_q <= act_mode_e'(mode);
          cnt    <= '0;
        end
        BUSY:  begin
          if (cnt != LAST_IDX) cnt <= cnt + 1'b1;
          drain_cnt <= 1'b0;
        end
        DRAIN: drain_cnt <= ~drain_cnt;
        default: ;
      endcase
    end
  end

  // Next-state logic; issue stops at LEN-1 so the counter never wraps.
  always_comb begin
    state_nxt = state;
    case (state)
      READY:   if (start) state_nxt = BUSY;
      BUSY:    if (cnt == LAST_IDX) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt) state_nxt = READY;
      default: state_nxt = READY;
    endcase
  end

  assign src_sel = (state == BUSY) ? cnt : '0;
  assign ready   = (state == READY);
  assign busy    = ~ready;
  assign done    = (state == DRAIN) && drain_cnt;

  // Saturating add: overflow shows as disagreement between the top two sum bits.
  always_comb begin
    sum = {src_data[15], src_data} + {bias_data[15], bias_data};
    if (sum[16] != sum[15]) sat = sum[16] ? 16'sh8000 : 16'sh7FFF;
    else                    sat = sum[15:0];
  end

  // Stage 1: capture the saturated sum for each issued element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sat   <= '0;
      s1_valid <= 1'b0;
      s1_idx   <= '0;
    end else begin
      s1_sat   <= sat;
      s1_valid <= (state == BUSY);
      s1_idx   <= cnt;
    end
  end

  hard_act u_hard_act (
    .mode (mode_q),
    .x    (s1_sat),
    .y    (act_y)
  );

  // Stage 2: register the activated result and its write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_data  <= '0;
      dst_sel   <= '0;
      dst_write <= 1'b0;
    end else begin
      dst_data  <= act_y;
      dst_sel   <= s1_idx;
      dst_write <= s1_valid;
    end
  end

endmodule

// File: tb/tb_bias_act.sv
// Directed, table-driven bench for bias_act (LEN=4).
module tb_bias_act;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [15:0] src_data, bias_data;
  logic [1:0]  src_sel, dst_sel;
  logic [15:0] dst_data;
  logic        dst_write, ready, busy, done;

  logic [15:0] src_mem  [4];
  logic [15:0] bias_mem [4];

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]        mode;
    logic [0:3][15:0]  src;
    logic [0:3][15:0]  bias;
    logic [0:3][15:0]  exp;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  assign src_data  = src_mem[src_sel];
  assign bias_data = bias_mem[src_sel];

  bias_act #(.LEN(4), .IDX_BITS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .src_data  (src_data),
    .bias_data (bias_data),
    .src_sel   (src_sel),
    .dst_sel   (dst_sel),
    .dst_data  (dst_data),
    .dst_write (dst_write),
    .ready     (ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " ready"},     32'(ready),     32'd1);
    check({tag, " busy"},      32'(busy),      32'd0);
    check({tag, " src_sel"},   32'(src_sel),   32'd0);
    check({tag, " dst_sel"},   32'(dst_sel),   32'd0);
    check({tag, " dst_data"},  32'(dst_data),  32'd0);
    check({tag, " dst_write"}, 32'(dst_write), 32'd0);
    check({tag, " done"},      32'(done),      32'd0);
  endtask

  // Start a run in the current cycle T (called just after a negedge with ready=1),
  // then check every cycle T+1..T+9. Mode is scrambled and start pulsed during the
  // run to show both are ignored.
  task automatic run_vec(input vec_t v, input string tag);
    for (int i = 0; i < 4; i++) begin
      src_mem[i]  = v.src[i];
      bias_mem[i] = v.bias[i];
    end
    check({tag, " ready at start"}, 32'(ready), 32'd1);
    start = 1'b1;
    mode  = v.mode;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      mode  = ~v.mode;
      start = (c == 2 || c == 5 || c == 6);
      check($sformatf("%s c%0d dst_write", tag, c), 32'(dst_write), 32'((c >= 3) && (c <= 6)));
      check($sformatf("%s c%0d done", tag, c), 32'(done), 32'(c == 6));
      check($sformatf("%s c%0d ready", tag, c), 32'(ready), 32'(c >= 7));
      check($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'(c < 7));
      if (c >= 1 && c <= 4)
        check($sformatf("%s c%0d src_sel", tag, c), 32'(src_sel), 32'(c - 1));
      if (c >= 3 && c <= 6) begin
        check($sformatf("%s c%0d dst_sel", tag, c), 32'(dst_sel), 32'(c - 3));
        check($sformatf("%s c%0d dst_data", tag, c), 32'(dst_data), 32'(v.exp[c-3]));
      end
    end
    start = 1'b0;
  endtask

  initial begin
    // ReLU from the test plan.
    vecs[0] = '{mode: 2'd1,
                src:  {16'h0100, 16'hFF00, 16'h0080, 16'h7F00},
                bias: {16'h0000, 16'h0000, 16'h0000, 16'h0000},
                exp:  {16'h0100, 16'h0000, 16'h0080, 16'h7F00}};
    // Pass-through with positive/negative saturation and plain adds.
    vecs[1] = '{mode: 2'd0,
                src:  {16'h7F00, 16'h8100, 16'h0001, 16'hFFFF},
                bias: {16'h0200, 16'hFE00, 16'h0002, 16'h0001},
                exp:  {16'h7FFF, 16'h8000, 16'h0003, 16'h0000}};
    // Hard-sigmoid from the test plan.
    vecs[2] = '{mode: 2'd2,
                src:  {16'h0000, 16'h0400, 16'hFC00, 16'h0100},
                bias: {16'h0000, 16'h0000, 16'h0000, 16'h0000},
                exp:  {16'h0080, 16'h0100, 16'h0000, 16'h00C0}};
    // Hard-tanh: upper clamp, in-range negative, lower clamp, small positive.
    vecs[3] = '{mode: 2'd3,
                src:  {16'h0300, 16'hFF80, 16'hFD00, 16'h0050},
                bias: {16'h0000, 16'h0000, 16'h0000, 16'h0000},
                exp:  {16'h0100, 16'hFF80, 16'hFF00, 16'h0050}};
    // ReLU where the bias drives the sum negative, and a saturated positive.
    vecs[4] = '{mode: 2'd1,
                src:  {16'h0100, 16'h0010, 16'h7000, 16'hFF00},
                bias: {16'hFE00, 16'h0020, 16'h2000, 16'h0180},
                exp:  {16'h0000, 16'h0030, 16'h7FFF, 16'h0080}};
    // Hard-sigmoid with bias: -0x200 -> 0, 0x200 -> 0x100 exactly, -0x100 -> 0x40, saturated neg -> 0.
    vecs[5] = '{mode: 2'd2,
                src:  {16'hFF00, 16'h0100, 16'hFF80, 16'h8000},
                bias: {16'hFF00, 16'h0100, 16'hFF80, 16'h8000},
                exp:  {16'h0000, 16'h0100, 16'h0040, 16'h0000}};

    for (int i = 0; i < 4; i++) begin
      src_mem[i]  = 16'h0;
      bias_mem[i] = 16'h0;
    end
    start = 1'b0;
    mode  = 2'd0;
    rst_n = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 6; k++) begin
      run_vec(vecs[k], $sformatf("vec%0d", k));
    end

    // Reset mid-run: start at T, drop rst_n in cycle T+4.
    for (int i = 0; i < 4; i++) begin
      src_mem[i]  = 16'h0100;
      bias_mem[i] = 16'h0000;
    end
    start = 1'b1;
    mode  = 2'd0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("midrun write before reset", 32'(dst_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrun");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("held reset c%0d dst_write", c), 32'(dst_write), 32'd0);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("post reset c%0d dst_write", c), 32'(dst_write), 32'd0);
      check($sformatf("post reset c%0d ready", c), 32'(ready), 32'd1);
    end

    // A fresh run after release completes normally.
    run_vec(vecs[3], "after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bias_act.md
# bias_act

Post-matmul vector stage for the RNN accelerator. After `matmul` finishes and raises `ready`, this block reads its accumulated Q8.8 result vector one element at a time. It drives `matmul`'s `sel` and also reads a bias tensor at the same index. For each element it adds the bias with saturation, applies a selectable hard activation, and writes the result into a destination `tensor_1d` through a 2-stage pipeline at one element per cycle.

## Interface
Parameters:
- `LEN`, default 4: number of vector elements processed per run.
- `IDX_BITS`, default 2: width of the index outputs; LEN <= 2**IDX_BITS.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a run; sampled only while `ready`=1.
- `mode`  in  2  activation select, latched at start: 0 pass, 1 ReLU, 2 hard-sigmoid, 3 hard-tanh.
- `src_data`  in  16  signed Q8.8 source element at `src_sel` (matmul `data_out`), combinational, same cycle.
- `bias_data`  in  16  signed Q8.8 bias element at `src_sel`, combinational, same cycle.
- `src_sel`  out  IDX_BITS  read index into source and bias.
- `dst_sel`  out  IDX_BITS  write index into the destination tensor.
- `dst_data`  out  16  signed Q8.8 activated result.
- `dst_write`  out  1  destination write strobe, one cycle per element.
- `ready`  out  1  idle; a run can be accepted.
- `busy`  out  1  equals ~`ready`.
- `done`  out  1  one-cycle pulse, coincident with the last `dst_write`.

## Operation
- FSM states:
  - READY: `start` → BUSY; latch `mode`; issue counter := 0.
  - BUSY: issue counter 0..LEN-1, one per cycle; `src_sel` = counter; after LEN-1 → DRAIN.
  - DRAIN: 2 cycles, then → READY.
- `src_sel` = 0 outside BUSY.
- Stage 1 register, capturing each issued element:
  - sat = clamp(sext17(`src_data`) + sext17(`bias_data`), -32768, 32767);
  - valid bit;
  - index.
- Stage 2 register: act(sat) into `dst_data`; `dst_sel` = index; `dst_write` = stage-1 valid.
- Activation, all signed 16-bit, ONE = 256, HALF = 128:
  - mode 0: x.
  - mode 1: x<0 ? 0 : x.
  - mode 2: clamp((x>>>2)+HALF, 0, ONE).
  - mode 3: clamp(x, -ONE, ONE).
- `start` while busy: ignored; no queuing.
- `mode` changes after start: no effect until the next run.
- Reset, including mid-run: immediately abort, no further writes, all state cleared.
- Reset values: state READY, `ready`=1, `busy`=0, `src_sel`=0, `dst_sel`=0, `dst_data`=0, `dst_write`=0, `done`=0, pipeline valids 0.

## Timing
- `start` sampled high at the rising edge ending cycle T.
- BUSY occupies cycles T+1..T+LEN; element i is read in cycle T+1+i.
- Element i has `dst_write`=1 in cycle T+3+i. Latency is 2 cycles from read to write strobe.
- Writes are back-to-back with no gaps: T+3..T+2+LEN.
- DRAIN occupies T+1+LEN..T+2+LEN. `done`=1 in cycle T+2+LEN only.
- `ready`=1 from T+3+LEN. A new `start` is accepted in that same cycle.
- Index wrap: the counter never exceeds LEN-1; LEN = 2**IDX_BITS must work without overflow.

## Structure
- Package `act_pkg`:
  - state enum {READY, BUSY, DRAIN};
  - mode enum {ACT_PASS, ACT_RELU, ACT_HSIG, ACT_HTANH};
  - constants Q_ONE=256, Q_HALF=128.
- Sub-module `hard_act`: combinational (`mode`, x[15:0]) → y[15:0] implementing the activation table. Instantiated between stage 1 and stage 2. Unit-testable alone.

## Test plan
- ReLU, LEN=4, bias 0, src {0x0100, 0xFF00, 0x0080, 0x7F00} → writes idx0..3 = {0x0100, 0x0000, 0x0080, 0x7F00}.
- Saturation, mode 0:
  - src 0x7F00 + bias 0x0200 → 0x7FFF;
  - src 0x8100 + bias 0xFE00 → 0x8000.
- Hard-sigmoid, src {0x0000, 0x0400, 0xFC00, 0x0100}, bias 0 → {0x0080, 0x0100, 0x0000, 0x00C0}.
- Hard-tanh, src {0x0300, 0xFF80}, bias {0x0000, 0x0000} → {0x0100, 0xFF80}.
- Timing, start at cycle T (LEN=4):
  - `dst_write` high exactly in T+3..T+6 with `dst_sel` 0,1,2,3;
  - `done` only at T+6;
  - `ready` at T+7;
  - `start` pulses during T+1..T+6 cause no second run.
- Reset mid-run: assert `rst_n`=0 in cycle T+4 → outputs at reset values immediately, no further `dst_write`. A fresh start after release completes normally.
